// File: rtl/mm_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
// Holds the access-type / access-length encodings produced by the execute
// stage, the stage FSM encoding, and small helpers that turn a store request
// into bus byte enables and lane-shifted write data.
package mm_stage_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_TYPE_R2R = 2'd0,
    MEM_ACCESS_TYPE_M2R = 2'd1,
    MEM_ACCESS_TYPE_R2M = 2'd2
  } mem_type_e;

  typedef enum logic [2:0] {
    MEM_ACCESS_LENGTH_BYTE       = 3'd0,
    MEM_ACCESS_LENGTH_HALF       = 3'd1,
    MEM_ACCESS_LENGTH_WORD       = 3'd2,
    MEM_ACCESS_LENGTH_LEFT_WORD  = 3'd3,
    MEM_ACCESS_LENGTH_RIGHT_WORD = 3'd4
  } mem_len_e;

  typedef enum logic {
    MM_IDLE   = 1'b0,
    MM_ACCESS = 1'b1
  } mm_state_e;

  // Only naturally-aligned half/word accesses are legal; the unaligned
  // LWL/LWR/SWL/SWR family never faults.
  function automatic logic isMisaligned(input logic [2:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      MEM_ACCESS_LENGTH_HALF: bad = offset[0];
      MEM_ACCESS_LENGTH_WORD: bad = |offset;
      default:                bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Loads always fetch the whole word; lane selection happens on return.
  function automatic logic [3:0] storeByteEn(input logic write, input logic [2:0] size,
                                             input logic [1:0] offset);
    logic [3:0] be;
    be = 4'b1111;
    if (write) begin
      case (size)
        MEM_ACCESS_LENGTH_BYTE: be = 4'b0001 << offset;
        MEM_ACCESS_LENGTH_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
        MEM_ACCESS_LENGTH_LEFT_WORD: begin
          case (offset)
            2'd0:    be = 4'b0001;
            2'd1:    be = 4'b0011;
            2'd2:    be = 4'b0111;
            default: be = 4'b1111;
          endcase
        end
        MEM_ACCESS_LENGTH_RIGHT_WORD: begin
          case (offset)
            2'd0:    be = 4'b1111;
            2'd1:    be = 4'b1110;
            2'd2:    be = 4'b1100;
            default: be = 4'b1000;
          endcase
        end
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  // SWL places the top bytes of rt in the low lanes; SWR places the low
  // bytes of rt in the high lanes. Byte/half stores replicate the value so
  // the byte enables alone pick the lane.
  function automatic logic [31:0] storeWdata(input logic [2:0] size, input logic [1:0] offset,
                                             input logic [31:0] rt);
    logic [31:0] wd;
    wd = rt;
    case (size)
      MEM_ACCESS_LENGTH_BYTE: wd = {4{rt[7:0]}};
      MEM_ACCESS_LENGTH_HALF: wd = {2{rt[15:0]}};
      MEM_ACCESS_LENGTH_LEFT_WORD: begin
        case (offset)
          2'd0:    wd = {24'd0, rt[31:24]};
          2'd1:    wd = {16'd0, rt[31:16]};
          2'd2:    wd = {8'd0, rt[31:8]};
          default: wd = rt;
        endcase
      end
      MEM_ACCESS_LENGTH_RIGHT_WORD: begin
        case (offset)
          2'd0:    wd = rt;
          2'd1:    wd = {rt[23:0], 8'd0};
          2'd2:    wd = {rt[15:0], 16'd0};
          default: wd = {rt[7:0], 24'd0};
        endcase
      end
      default: wd = rt;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mm_stage_load_align.sv
// mm_load_align: combinational load-data formatter.
// Ports:
//   size_i    access length (mem_len_e encoding)
//   signed_i  sign-extend byte/half loads
//   offset_i  byte offset within the word (addr[1:0])
//   rdata_i   word returned by the bus
//   rt_i      old destination value, merged by LWL/LWR
//   data_o    value to write back
module mm_load_align
  import mm_stage_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] rt_i,
  output logic [31:0] data_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Pick the addressed lane(s) of the little-endian word, then extend or
  // merge. LWL fills the top of rt from the low memory bytes; LWR fills the
  // bottom of rt from the high memory bytes.
  always_comb begin
    case (offset_i)
      2'd0:    byteLane = rdata_i[7:0];
      2'd1:    byteLane = rdata_i[15:8];
      2'd2:    byteLane = rdata_i[23:16];
      default: byteLane = rdata_i[31:24];
    endcase
    halfLane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = rdata_i;
    case (size_i)
      MEM_ACCESS_LENGTH_BYTE: data_o = {{24{signed_i & byteLane[7]}}, byteLane};
      MEM_ACCESS_LENGTH_HALF: data_o = {{16{signed_i & halfLane[15]}}, halfLane};
      MEM_ACCESS_LENGTH_LEFT_WORD: begin
        case (offset_i)
          2'd0:    data_o = {rdata_i[7:0], rt_i[23:0]};
          2'd1:    data_o = {rdata_i[15:0], rt_i[15:0]};
          2'd2:    data_o = {rdata_i[23:0], rt_i[7:0]};
          default: data_o = rdata_i;
        endcase
      end
      MEM_ACCESS_LENGTH_RIGHT_WORD: begin
        case (offset_i)
          2'd0:    data_o = rdata_i;
          2'd1:    data_o = {rt_i[31:24], rdata_i[31:8]};
          2'd2:    data_o = {rt_i[31:16], rdata_i[31:16]};
          default: data_o = {rt_i[31:8], rdata_i[31:24]};
        endcase
      end
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mm_stage.sv
// mm_stage: memory-access pipeline stage.
// Accepts the execute stage's memory-access outputs, turns loads/stores into
// a word-aligned bus request, stalls upstream until the bus acknowledges,
// and registers the writeback result. Misaligned half/word accesses raise
// addr_error instead of reaching the bus.
// Ports:
//   clk, rst_n                     clock, synchronous active-high reset (1 = reset)
//   in_valid, mem_access_*         instruction from EX
//   val_output, bypass_reg_addr    R2R result / store data / LWL-LWR rt, dest reg
//   bus_req/we/addr/byte_en/wdata  bus request, held until bus_ack
//   bus_ack, bus_rdata             single-cycle completion and read data
//   stall_for_mem                  upstream must hold its inputs
//   wb_we, wb_reg_addr, wb_data    registered writeback
//   addr_error, addr_error_store   one-cycle fault pulse and its load/store qualifier
//   bad_vaddr                      last faulting address
module mm_stage
  import mm_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  mem_access_type,
  input  logic [2:0]  mem_access_size,
  input  logic        mem_access_signed,
  input  logic [31:0] mem_access_addr,
  input  logic [31:0] val_output,
  input  logic [4:0]  bypass_reg_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byte_en,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_for_mem,
  output logic        wb_we,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_data,
  output logic        addr_error,
  output logic        addr_error_store,
  output logic [31:0] bad_vaddr
);

  mm_state_e   state_q, state_d;
  logic        reqWe_q, reqWe_d;
  logic [31:0] reqAddr_q, reqAddr_d;
  logic [2:0]  reqSize_q, reqSize_d;
  logic        reqSigned_q, reqSigned_d;
  logic [31:0] reqRt_q, reqRt_d;
  logic [4:0]  reqReg_q, reqReg_d;
  logic [3:0]  reqBe_q, reqBe_d;
  logic [31:0] reqWdata_q, reqWdata_d;
  logic        wbWe_q, wbWe_d;
  logic [4:0]  wbReg_q, wbReg_d;
  logic [31:0] wbData_q, wbData_d;
  logic        addrErr_q, addrErr_d;
  logic        addrErrStore_q, addrErrStore_d;
  logic [31:0] badVaddr_q, badVaddr_d;
  logic        stall;
  logic        isMem;
  logic        isStore;
  logic [31:0] loadData;

  mm_load_align uLoadAlign (
    .size_i   (reqSize_q),
    .signed_i (reqSigned_q),
    .offset_i (reqAddr_q[1:0]),
    .rdata_i  (bus_rdata),
    .rt_i     (reqRt_q),
    .data_o   (loadData)
  );

  // Next-state and writeback logic. In IDLE the incoming instruction is
  // either written back directly (R2R), rejected as misaligned, or latched
  // as a bus request. In ACCESS we wait for bus_ack, then write back loads.
  always_comb begin
    state_d        = state_q;
    reqWe_d        = reqWe_q;
    reqAddr_d      = reqAddr_q;
    reqSize_d      = reqSize_q;
    reqSigned_d    = reqSigned_q;
    reqRt_d        = reqRt_q;
    reqReg_d       = reqReg_q;
    reqBe_d        = reqBe_q;
    reqWdata_d     = reqWdata_q;
    wbWe_d         = 1'b0;
    wbReg_d        = wbReg_q;
    wbData_d       = wbData_q;
    addrErr_d      = 1'b0;
    addrErrStore_d = 1'b0;
    badVaddr_d     = badVaddr_q;
    stall          = 1'b0;
    isStore        = (mem_access_type == MEM_ACCESS_TYPE_R2M);
    isMem          = (mem_access_type == MEM_ACCESS_TYPE_M2R) || isStore;
    case (state_q)
      MM_IDLE: begin
        if (in_valid) begin
          if (mem_access_type == MEM_ACCESS_TYPE_R2R) begin
            wbWe_d   = |bypass_reg_addr;
            wbReg_d  = bypass_reg_addr;
            wbData_d = val_output;
          end else if (isMem) begin
            if (isMisaligned(mem_access_size, mem_access_addr[1:0])) begin
              addrErr_d      = 1'b1;
              addrErrStore_d = isStore;
              badVaddr_d     = mem_access_addr;
            end else begin
              state_d     = MM_ACCESS;
              stall       = 1'b1;
              reqWe_d     = isStore;
              reqAddr_d   = mem_access_addr;
              reqSize_d   = mem_access_size;
              reqSigned_d = mem_access_signed;
              reqRt_d     = val_output;
              reqReg_d    = bypass_reg_addr;
              reqBe_d     = storeByteEn(isStore, mem_access_size, mem_access_addr[1:0]);
              reqWdata_d  = storeWdata(mem_access_size, mem_access_addr[1:0], val_output);
            end
          end
        end
      end
      MM_ACCESS: begin
        stall = !bus_ack;
        if (bus_ack) begin
          state_d = MM_IDLE;
          if (!reqWe_q) begin
            wbWe_d   = |reqReg_q;
            wbReg_d  = reqReg_q;
            wbData_d = loadData;
          end
        end
      end
      default: state_d = MM_IDLE;
    endcase
  end

  // All state, including the latched request, clears on reset so a reset
  // during ACCESS drops bus_req at the next edge and ignores a late ack.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q        <= MM_IDLE;
      reqWe_q        <= 1'b0;
      reqAddr_q      <= '0;
      reqSize_q      <= '0;
      reqSigned_q    <= 1'b0;
      reqRt_q        <= '0;
      reqReg_q       <= '0;
      reqBe_q        <= '0;
      reqWdata_q     <= '0;
      wbWe_q         <= 1'b0;
      wbReg_q        <= '0;
      wbData_q       <= '0;
      addrErr_q      <= 1'b0;
      addrErrStore_q <= 1'b0;
      badVaddr_q     <= '0;
    end else begin
      state_q        <= state_d;
      reqWe_q        <= reqWe_d;
      reqAddr_q      <= reqAddr_d;
      reqSize_q      <= reqSize_d;
      reqSigned_q    <= reqSigned_d;
      reqRt_q        <= reqRt_d;
      reqReg_q       <= reqReg_d;
      reqBe_q        <= reqBe_d;
      reqWdata_q     <= reqWdata_d;
      wbWe_q         <= wbWe_d;
      wbReg_q        <= wbReg_d;
      wbData_q       <= wbData_d;
      addrErr_q      <= addrErr_d;
      addrErrStore_q <= addrErrStore_d;
      badVaddr_q     <= badVaddr_d;
    end
  end

  assign bus_req          = (state_q == MM_ACCESS);
  assign bus_we           = bus_req & reqWe_q;
  assign bus_addr         = {reqAddr_q[31:2], 2'b00};
  assign bus_byte_en      = reqBe_q;
  assign bus_wdata        = reqWdata_q;
  assign stall_for_mem    = stall;
  assign wb_we            = wbWe_q;
  assign wb_reg_addr      = wbReg_q;
  assign wb_data          = wbData_q;
  assign addr_error       = addrErr_q;
  assign addr_error_store = addrErrStore_q;
  assign bad_vaddr        = badVaddr_q;

endmodule

// File: tb/tb_mm_stage.sv
// Self-checking bench for mm_stage: directed cases followed by randomized
// transactions compared against a byte-level reference model.
module tb_mm_stage;
  import mm_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  mem_access_type;
  logic [2:0]  mem_access_size;
  logic        mem_access_signed;
  logic [31:0] mem_access_addr;
  logic [31:0] val_output;
  logic [4:0]  bypass_reg_addr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall_for_mem;
  logic        wb_we;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_data;
  logic        addr_error;
  logic        addr_error_store;
  logic [31:0] bad_vaddr;

  int errors = 0;
  int checks = 0;

  mm_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .mem_access_type   (mem_access_type),
    .mem_access_size   (mem_access_size),
    .mem_access_signed (mem_access_signed),
    .mem_access_addr   (mem_access_addr),
    .val_output        (val_output),
    .bypass_reg_addr   (bypass_reg_addr),
    .bus_req           (bus_req),
    .bus_we            (bus_we),
    .bus_addr          (bus_addr),
    .bus_byte_en       (bus_byte_en),
    .bus_wdata         (bus_wdata),
    .bus_ack           (bus_ack),
    .bus_rdata         (bus_rdata),
    .stall_for_mem     (stall_for_mem),
    .wb_we             (wb_we),
    .wb_reg_addr       (wb_reg_addr),
    .wb_data           (wb_data),
    .addr_error        (addr_error),
    .addr_error_store  (addr_error_store),
    .bad_vaddr         (bad_vaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the stimulus never waits on the DUT, but guard against hangs.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference load result built byte by byte from the architectural rules.
  function automatic logic [31:0] modelLoad(input logic [2:0] sz, input logic sgn, input int a,
                                            input logic [31:0] mem, input logic [31:0] rt);
    logic [7:0]  m[4];
    logic [7:0]  r[4];
    logic [15:0] h;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      m[i] = mem[8*i +: 8];
      r[i] = rt[8*i +: 8];
    end
    res = mem;
    case (sz)
      MEM_ACCESS_LENGTH_BYTE: res = sgn ? {{24{m[a][7]}}, m[a]} : {24'd0, m[a]};
      MEM_ACCESS_LENGTH_HALF: begin
        h   = {m[a+1], m[a]};
        res = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      end
      MEM_ACCESS_LENGTH_LEFT_WORD: begin
        for (int i = 0; i <= a; i++) r[3-a+i] = m[i];
        res = {r[3], r[2], r[1], r[0]};
      end
      MEM_ACCESS_LENGTH_RIGHT_WORD: begin
        for (int i = a; i < 4; i++) r[i-a] = m[i];
        res = {r[3], r[2], r[1], r[0]};
      end
      default: res = mem;
    endcase
    return res;
  endfunction

  // Reference store lanes: which bytes are written and what they carry.
  task automatic modelStore(input logic [2:0] sz, input int a, input logic [31:0] rt,
                            output logic [3:0] be, output logic [31:0] wd);
    logic [7:0] r[4];
    logic [7:0] lane[4];
    for (int i = 0; i < 4; i++) begin
      r[i]    = rt[8*i +: 8];
      lane[i] = 8'd0;
    end
    be = 4'b0000;
    wd = rt;
    case (sz)
      MEM_ACCESS_LENGTH_BYTE: begin
        be[a] = 1'b1;
        wd    = {4{rt[7:0]}};
      end
      MEM_ACCESS_LENGTH_HALF: begin
        be[a]   = 1'b1;
        be[a+1] = 1'b1;
        wd      = {2{rt[15:0]}};
      end
      MEM_ACCESS_LENGTH_LEFT_WORD: begin
        for (int i = 0; i <= a; i++) begin
          be[i]   = 1'b1;
          lane[i] = r[3-a+i];
        end
        wd = {lane[3], lane[2], lane[1], lane[0]};
      end
      MEM_ACCESS_LENGTH_RIGHT_WORD: begin
        for (int i = a; i < 4; i++) begin
          be[i]   = 1'b1;
          lane[i] = r[i-a];
        end
        wd = {lane[3], lane[2], lane[1], lane[0]};
      end
      default: begin
        be = 4'b1111;
        wd = rt;
      end
    endcase
  endtask

  // Drive one instruction through the stage, checking every cycle against
  // the model. Returns the observed writeback data and stall-cycle count.
  task automatic applyStimulus(input logic [1:0] ty, input logic [2:0] sz, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] val,
                               input logic [4:0] rd, input int waits, input logic [31:0] rdata,
                               output logic [31:0] gotWb, output int stallCycles);
    int         a;
    logic       isMemT;
    logic       isSt;
    logic       mis;
    logic       expWe;
    logic [3:0] expBe;
    logic [31:0] expWd;
    a      = int'(addr[1:0]);
    isSt   = (ty == MEM_ACCESS_TYPE_R2M);
    isMemT = isSt || (ty == MEM_ACCESS_TYPE_M2R);
    mis    = isMemT && (((sz == MEM_ACCESS_LENGTH_HALF) && (a % 2 != 0)) ||
                        ((sz == MEM_ACCESS_LENGTH_WORD) && (a != 0)));
    stallCycles = 0;

    in_valid          = 1'b1;
    mem_access_type   = ty;
    mem_access_size   = sz;
    mem_access_signed = sgn;
    mem_access_addr   = addr;
    val_output        = val;
    bypass_reg_addr   = rd;
    bus_ack           = 1'b0;
    #1;
    checkOutput("stall_accept", 32'(stall_for_mem), 32'(isMemT && !mis));
    if (stall_for_mem) stallCycles++;
    step();

    if (!isMemT) begin
      in_valid = 1'b0;
      checkOutput("r2r_wb_we", 32'(wb_we), 32'(rd != 5'd0));
      if (rd != 5'd0) begin
        checkOutput("r2r_wb_reg", 32'(wb_reg_addr), 32'(rd));
        checkOutput("r2r_wb_data", wb_data, val);
      end
      checkOutput("r2r_bus_req", 32'(bus_req), 32'd0);
      checkOutput("r2r_addr_err", 32'(addr_error), 32'd0);
    end else if (mis) begin
      in_valid = 1'b0;
      checkOutput("mis_addr_err", 32'(addr_error), 32'd1);
      checkOutput("mis_store", 32'(addr_error_store), 32'(isSt));
      checkOutput("mis_bad_vaddr", bad_vaddr, addr);
      checkOutput("mis_bus_req", 32'(bus_req), 32'd0);
      checkOutput("mis_wb_we", 32'(wb_we), 32'd0);
      #1;
      checkOutput("mis_stall", 32'(stall_for_mem), 32'd0);
      step();
      checkOutput("mis_pulse_end", 32'(addr_error), 32'd0);
      checkOutput("mis_bad_hold", bad_vaddr, addr);
      checkOutput("mis_no_req", 32'(bus_req), 32'd0);
    end else begin
      if (isSt) modelStore(sz, a, val, expBe, expWd);
      else begin
        expBe = 4'b1111;
        expWd = 32'd0;
      end
      checkOutput("bus_req", 32'(bus_req), 32'd1);
      checkOutput("bus_addr", bus_addr, {addr[31:2], 2'b00});
      checkOutput("bus_we", 32'(bus_we), 32'(isSt));
      checkOutput("bus_be", 32'(bus_byte_en), 32'(expBe));
      if (isSt) checkOutput("bus_wdata", bus_wdata, expWd);
      for (int w = 0; w < waits; w++) begin
        checkOutput("stall_wait", 32'(stall_for_mem), 32'd1);
        if (stall_for_mem) stallCycles++;
        step();
        checkOutput("req_held", 32'(bus_req), 32'd1);
      end
      bus_ack   = 1'b1;
      bus_rdata = rdata;
      #1;
      checkOutput("stall_ack", 32'(stall_for_mem), 32'd0);
      step();
      bus_ack  = 1'b0;
      in_valid = 1'b0;
      expWe    = !isSt && (rd != 5'd0);
      checkOutput("mem_wb_we", 32'(wb_we), 32'(expWe));
      if (expWe) begin
        checkOutput("mem_wb_reg", 32'(wb_reg_addr), 32'(rd));
        checkOutput("mem_wb_data", wb_data, modelLoad(sz, sgn, a, rdata, val));
      end
      checkOutput("req_drop", 32'(bus_req), 32'd0);
    end
    gotWb = wb_data;
    #1;
  endtask

  initial begin
    logic [31:0] gotWb;
    int          stallCycles;
    logic [1:0]  ty;
    logic [2:0]  sz;
    logic [31:0] addr;
    int          waits;
    int          expStall;
    logic        misR;

    rst_n             = 1'b1;
    in_valid          = 1'b0;
    mem_access_type   = 2'd0;
    mem_access_size   = 3'd0;
    mem_access_signed = 1'b0;
    mem_access_addr   = 32'd0;
    val_output        = 32'd0;
    bypass_reg_addr   = 5'd0;
    bus_ack           = 1'b0;
    bus_rdata         = 32'd0;
    repeat (3) step();

    checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("rst_bus_we", 32'(bus_we), 32'd0);
    checkOutput("rst_bus_addr", bus_addr, 32'd0);
    checkOutput("rst_bus_be", 32'(bus_byte_en), 32'd0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
    checkOutput("rst_stall", 32'(stall_for_mem), 32'd0);
    checkOutput("rst_wb_we", 32'(wb_we), 32'd0);
    checkOutput("rst_wb_reg", 32'(wb_reg_addr), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_addr_err", 32'(addr_error), 32'd0);
    checkOutput("rst_err_store", 32'(addr_error_store), 32'd0);
    checkOutput("rst_bad_vaddr", bad_vaddr, 32'd0);
    rst_n = 1'b0;
    step();

    applyStimulus(MEM_ACCESS_TYPE_R2R, MEM_ACCESS_LENGTH_WORD, 1'b0, 32'd0, 32'h0000_1234,
                  5'd5, 0, 32'd0, gotWb, stallCycles);
    checkOutput("dir_r2r", gotWb, 32'h0000_1234);
    step();
    checkOutput("idle_wb_we", 32'(wb_we), 32'd0);

    applyStimulus(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_BYTE, 1'b1, 32'h0000_0103,
                  32'd0, 5'd7, 3, 32'h80FF_FFFF, gotWb, stallCycles);
    checkOutput("dir_lb", gotWb, 32'hFFFF_FF80);
    checkOutput("dir_lb_stall", 32'(stallCycles), 32'd4);

    applyStimulus(MEM_ACCESS_TYPE_R2M, MEM_ACCESS_LENGTH_HALF, 1'b0, 32'h0000_0202,
                  32'h0000_ABCD, 5'd0, 1, 32'd0, gotWb, stallCycles);

    applyStimulus(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_LEFT_WORD, 1'b0, 32'h0000_0001,
                  32'h1122_3344, 5'd9, 0, 32'hAABB_CCDD, gotWb, stallCycles);
    checkOutput("dir_lwl", gotWb, 32'hCCDD_3344);
    checkOutput("dir_zero_wait", 32'(stallCycles), 32'd1);
    applyStimulus(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_RIGHT_WORD, 1'b0, 32'h0000_0002,
                  32'h1122_3344, 5'd9, 2, 32'hAABB_CCDD, gotWb, stallCycles);
    checkOutput("dir_lwr", gotWb, 32'h1122_AABB);

    applyStimulus(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_WORD, 1'b0, 32'h0000_0006,
                  32'd0, 5'd3, 0, 32'd0, gotWb, stallCycles);
    checkOutput("dir_lw_mis_stall", 32'(stallCycles), 32'd0);

    // A stray ack while idle must not start or complete anything.
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    step();
    bus_ack = 1'b0;
    checkOutput("idle_ack_req", 32'(bus_req), 32'd0);
    checkOutput("idle_ack_wb", 32'(wb_we), 32'd0);

    // Reset in the middle of an access, then a late ack.
    in_valid        = 1'b1;
    mem_access_type = MEM_ACCESS_TYPE_M2R;
    mem_access_size = MEM_ACCESS_LENGTH_WORD;
    mem_access_addr = 32'h0000_0040;
    bypass_reg_addr = 5'd3;
    step();
    checkOutput("rstmid_req", 32'(bus_req), 32'd1);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();
    checkOutput("rstmid_req_drop", 32'(bus_req), 32'd0);
    rst_n     = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'h1234_5678;
    step();
    bus_ack = 1'b0;
    checkOutput("rstmid_late_req", 32'(bus_req), 32'd0);
    checkOutput("rstmid_late_wb", 32'(wb_we), 32'd0);
    applyStimulus(MEM_ACCESS_TYPE_R2R, MEM_ACCESS_LENGTH_WORD, 1'b0, 32'd0, 32'h0BAD_F00D,
                  5'd12, 0, 32'd0, gotWb, stallCycles);
    checkOutput("rstmid_idle", gotWb, 32'h0BAD_F00D);

    for (int n = 0; n < 200; n++) begin
      ty    = 2'($urandom_range(0, 2));
      sz    = 3'($urandom_range(0, 4));
      addr  = $urandom;
      waits = $urandom_range(0, 3);
      misR  = ((sz == MEM_ACCESS_LENGTH_HALF) && addr[0]) ||
              ((sz == MEM_ACCESS_LENGTH_WORD) && (addr[1:0] != 2'd0));
      expStall = (ty != MEM_ACCESS_TYPE_R2R && !misR) ? waits + 1 : 0;
      applyStimulus(ty, sz, 1'($urandom_range(0, 1)), addr, $urandom,
                    5'($urandom_range(0, 31)), waits, $urandom, gotWb, stallCycles);
      checkOutput("rnd_stall_cycles", 32'(stallCycles), 32'(expStall));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mm_stage.md
# mm_stage

Memory-access pipeline stage (step_mm), the consumer of the execute stage's memory-access outputs. It decodes access type, size and address into a word-aligned bus request with byte enables, and holds the pipeline stalled until the bus acknowledges. It aligns, sign-extends or merges load data (LWL/LWR) and forwards register-writeback results to the writeback stage. Misaligned accesses raise an address-error flag instead of touching the bus.

## Interface
Parameters:
- none; widths fixed by the shared definitions.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-high reset (name kept for codebase consistency; 1 = reset).
- in_valid  in  1  EX output register holds a valid instruction.
- mem_access_type  in  2  R2R / M2R / R2M.
- mem_access_size  in  3  BYTE / HALF / WORD / LEFT_WORD / RIGHT_WORD.
- mem_access_signed  in  1  sign-extend byte/half loads (LB/LH).
- mem_access_addr  in  32  effective byte address.
- val_output  in  32  R2R result, store data, or old rt value for LWL/LWR merge.
- bypass_reg_addr  in  5  destination register; 0 = no write.
- bus_req  out  1  request; held high until bus_ack.
- bus_we  out  1  1 = write.
- bus_addr  out  32  {addr[31:2], 2'b00}.
- bus_byte_en  out  4  little-endian byte lanes.
- bus_wdata  out  32  lane-shifted store data.
- bus_ack  in  1  single-cycle completion; valid only while bus_req is high.
- bus_rdata  in  32  read word, valid with bus_ack.
- stall_for_mem  out  1  upstream holds its inputs stable.
- wb_we  out  1  registered writeback strobe.
- wb_reg_addr  out  5  writeback register.
- wb_data  out  32  writeback value.
- addr_error  out  1  one-cycle pulse on a misaligned access.
- addr_error_store  out  1  qualifies addr_error: 1 = store.
- bad_vaddr  out  32  faulting address; holds until the next error.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, in_valid, R2R: register wb_we = (bypass_reg_addr != 0), wb_reg_addr, and wb_data = val_output. No stall.
- IDLE, in_valid, M2R/R2M, aligned: latch the request, go to ACCESS, assert stall_for_mem combinationally this cycle.
- Misaligned: HALF with addr[0]=1, or WORD with addr[1:0]≠0. Pulse addr_error next cycle, latch bad_vaddr, set wb_we=0, issue no request, stay in IDLE.
- ACCESS: bus_req=1, with outputs driven from the latch. stall_for_mem = !bus_ack. On bus_ack, register the writeback (loads only; stores give wb_we=0) and return to IDLE.
- Byte enables:
  - SB: 1<<a.
  - SH: a[1] ? 1100 : 0011.
  - SW: 1111.
  - SWL: a=0..3 → 0001, 0011, 0111, 1111.
  - SWR: a=0..3 → 1111, 1110, 1100, 1000.
- Write data:
  - SB/SH: value replicated across lanes.
  - SWL: rt>>(8*(3-a)).
  - SWR: rt<<(8*a).
- Load data:
  - Byte/half: extracted lane, sign- or zero-extended.
  - LWL a: {mem[8a+7:0], rt[23-8a:0]}; a=3 gives mem.
  - LWR a: {rt[31:32-8a], mem[31:8a]}; a=0 gives mem.
- Invalid/idle cycles: wb_we=0.

## Timing
- Reset values: state IDLE; bus_req, bus_we, wb_we, addr_error, addr_error_store, stall_for_mem = 0; bus_addr, bus_byte_en, bus_wdata, wb_data, bad_vaddr = 0; wb_reg_addr = 0.
- R2R latency: 1 cycle.
- Memory latency: accept at cycle N, bus_req from N+1, ack at cycle M ≥ N+1, wb_we at M+1. Zero-wait bus gives 2 cycles.
- bus_ack in the same cycle bus_req first rises is legal.
- bus_ack while IDLE is ignored.
- Back-to-back: the instruction after an ack is accepted in cycle M+1.
- Reset during ACCESS: bus_req drops next edge; a late ack is ignored.

## Structure
- Shared defs hold MEM_ACCESS_TYPE_* and MEM_ACCESS_LENGTH_* (3-bit) and the IDLE/ACCESS encodings.
- Sub-module mm_load_align: purely combinational load extraction and LWL/LWR merge.

## Test plan
- R2R: val 0x1234, reg 5 → cycle+1 wb_we=1, wb_data=0x1234, no bus_req.
- LB signed, addr 0x103, rdata 0x80FFFFFF, ack after 3 waits → bus_addr 0x100, be 1111, wb_data 0xFFFFFF80, stall high for 4 cycles.
- SH addr 0x202, val 0xABCD → be 1100, wdata 0xABCDABCD, bus_we=1, wb_we=0.
- LWL addr 0x1, rt 0x11223344, rdata 0xAABBCCDD → wb_data 0xCCDD3344. LWR addr 0x2 → 0x1122AABB.
- LW addr 0x6 → addr_error pulse, addr_error_store=0, bad_vaddr 0x6, no bus_req.
- Reset asserted mid-ACCESS, then ack → bus_req 0, wb_we 0, state IDLE.
